// File: rtl/display_frame_serializer.sv
// ============================================================================
// display_frame_serializer: encodes BCD digits into active-low segment bytes
// and shifts segment and one-hot select words out MSB-first with byte strobes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module display_frame_serializer #(
  parameter int NUM_DIGITS = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dec_on,
  output logic                      digit_data_ser,
  output logic                      control_data_ser,
  output logic                      control_reg_clk,
  output logic                      frame_start,
  output logic                      busy
);

  localparam int c_word_w = 8 * NUM_DIGITS;
  localparam int c_cnt_w  = $clog2(c_word_w);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(c_word_w - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t                r_state;
  logic [c_word_w-1:0]   r_dig_sr;
  logic [c_word_w-1:0]   r_ctl_sr;
  logic [c_cnt_w-1:0]    r_bit_cnt;
  logic                  r_strobe;
  logic                  r_frame_start;
  logic                  r_busy;

  logic [c_word_w-1:0]   w_dig_word;
  logic [c_word_w-1:0]   w_ctl_word;

  // Segment byte {a,b,c,d,e,f,g,dp}, active-low; non-decimal codes blank.
  function automatic logic [7:0] seg_encode(input logic [3:0] code, input logic dp);
    logic [7:0] seg;
    case (code)
      4'd0:    seg = 8'h03;
      4'd1:    seg = 8'h9F;
      4'd2:    seg = 8'h25;
      4'd3:    seg = 8'h0D;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h49;
      4'd6:    seg = 8'h41;
      4'd7:    seg = 8'h1F;
      4'd8:    seg = 8'h01;
      4'd9:    seg = 8'h09;
      default: seg = 8'hFF;
    endcase
    return {seg[7:1], seg[0] & ~dp};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_bytes
      assign w_dig_word[8*gi +: 8] = seg_encode(digits_in[4*gi +: 4], dec_on[gi]);
      assign w_ctl_word[8*gi +: 8] = 8'h01 << gi;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_dig_sr      <= '0;
      r_ctl_sr      <= '0;
      r_bit_cnt     <= '0;
      r_strobe      <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_strobe <= 1'b0;
          if (run) begin
            r_state       <= S_SHIFT;
            r_dig_sr      <= w_dig_word;
            r_ctl_sr      <= w_ctl_word;
            r_bit_cnt     <= '0;
            r_frame_start <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        S_SHIFT: begin
          // Strobe lands in the cycle after each byte's last bit was presented.
          r_strobe <= (r_bit_cnt[2:0] == 3'd7);
          if (r_bit_cnt == c_last_bit) begin
            if (run) begin
              r_dig_sr      <= w_dig_word;
              r_ctl_sr      <= w_ctl_word;
              r_bit_cnt     <= '0;
              r_frame_start <= 1'b1;
            end else begin
              r_state       <= S_IDLE;
              r_dig_sr      <= '0;
              r_ctl_sr      <= '0;
              r_bit_cnt     <= '0;
              r_frame_start <= 1'b0;
              r_busy        <= 1'b0;
            end
          end else begin
            r_dig_sr      <= {r_dig_sr[c_word_w-2:0], 1'b0};
            r_ctl_sr      <= {r_ctl_sr[c_word_w-2:0], 1'b0};
            r_bit_cnt     <= r_bit_cnt + 1'b1;
            r_frame_start <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign digit_data_ser   = r_dig_sr[c_word_w-1];
  assign control_data_ser = r_ctl_sr[c_word_w-1];
  assign control_reg_clk  = r_strobe;
  assign frame_start      = r_frame_start;
  assign busy             = r_busy;

endmodule

`default_nettype wire
